// File: rtl/ibex_instr_bus_responder.sv
// Instruction-side bus responder: grants fetch requests, answers them from a
// preloadable word memory after a fixed latency, in grant order.
module ibex_instr_bus_responder #(
    parameter int unsigned AddrW          = 10,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,
    input  logic             stall_i,
    input  logic             load_we_i,
    input  logic [AddrW-1:0] load_addr_i,
    input  logic [31:0]      load_wdata_i,
    output logic             busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [CntW-1:0]        count;
    logic                   gnt;
    logic                   rvalid_q;
    logic [31:0]            rdata_q;
    logic [AddrW-1:0]       req_idx;
    logic                   req_err;

    logic [RespLatency-1:0] pipe_valid;
    logic [RespLatency-1:0] pipe_err;
    logic [AddrW-1:0]       pipe_idx [RespLatency];

    logic [RespLatency-1:0] in_valid;
    logic [RespLatency-1:0] in_err;
    logic [AddrW-1:0]       in_idx   [RespLatency];

    logic [31:0]            mem      [2**AddrW];

    logic                   unused;

    assign req_idx = instr_addr_i[AddrW+1:2];
    assign req_err = |instr_addr_i[31:AddrW+2];

    assign gnt = instr_req_i & ~stall_i & ~rst_i & (count < CntW'(MaxOutstanding));

    // in_* is the value each stage captures on the next edge; index 0 is the
    // fresh grant, so the final stage's input also drives the memory read.
    always_comb begin
        in_valid[0] = gnt;
        in_err[0]   = req_err;
        in_idx[0]   = req_idx;
        for (int unsigned i = 1; i < RespLatency; i++) begin
            in_valid[i] = pipe_valid[i-1];
            in_err[i]   = pipe_err[i-1];
            in_idx[i]   = pipe_idx[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid <= in_valid;
        end
        pipe_err <= in_err;
        for (int unsigned i = 0; i < RespLatency; i++) begin
            pipe_idx[i] <= in_idx[i];
        end
    end

    assign rvalid_q = pipe_valid[RespLatency-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (gnt && !rvalid_q) begin
            count <= count + CntW'(1);
        end else if (!gnt && rvalid_q) begin
            count <= count - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_wdata_i;
        end
    end

    // Read uses the pre-edge memory contents, so a same-edge preload of the
    // same word is seen only by later reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (in_valid[RespLatency-1] && !in_err[RespLatency-1]) begin
            rdata_q <= mem[in_idx[RespLatency-1]];
        end else begin
            rdata_q <= '0;
        end
    end

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = rvalid_q & ~rst_i;
    assign instr_err_o    = rvalid_q & pipe_err[RespLatency-1] & ~rst_i;
    assign instr_rdata_o  = rst_i ? '0 : rdata_q;
    assign busy_o         = (count != '0) & ~rst_i;

    assign unused = ^{instr_addr_i[1:0], pipe_idx[RespLatency-1]};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (RespLatency >= 1 && RespLatency <= 4);
            assert (MaxOutstanding >= 1 && MaxOutstanding <= 4);
            assert (count <= CntW'(MaxOutstanding));
            assert (!(rvalid_q && count == '0));
        end
    end

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Scoreboard bench for ibex_instr_bus_responder: a cycle model predicts grant,
// count and read data; expected responses are queued and compared on rvalid.
module tb_ibex_instr_bus_responder;

    localparam int unsigned AW = 10;
    localparam int unsigned LAT = 2;
    localparam int unsigned MAXO = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic [31:0]   addr = '0;
    logic          stall = 1'b0;
    logic          lwe = 1'b0;
    logic [AW-1:0] laddr = '0;
    logic [31:0]   lwdata = '0;
    logic          gnt, rvalid, err, busy;
    logic [31:0]   rdata;

    ibex_instr_bus_responder #(
        .AddrW(AW),
        .RespLatency(LAT),
        .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .instr_req_i(req),
        .instr_addr_i(addr),
        .instr_gnt_o(gnt),
        .instr_rvalid_o(rvalid),
        .instr_rdata_o(rdata),
        .instr_err_o(err),
        .stall_i(stall),
        .load_we_i(lwe),
        .load_addr_i(laddr),
        .load_wdata_i(lwdata),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   due;
        logic [AW-1:0] idx;
        logic          err;
        logic [31:0]   data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [2**AW];
    int unsigned mcount = 0;
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    logic        last_gnt_dut;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive, check mid-cycle, advance the model, clock.
    task automatic step(input logic r, input logic [31:0] a, input logic s,
                        input logic we, input logic [AW-1:0] la, input logic [31:0] wd,
                        input logic rs);
        logic exp_g;
        logic exp_v;
        rst = rs; req = r; addr = a; stall = s; lwe = we; laddr = la; lwdata = wd;
        #3;
        exp_g = r && !s && !rs && (mcount < MAXO);
        exp_v = !rs && sb.size() > 0 && sb[0].due == cyc;
        check("gnt", {31'b0, gnt}, {31'b0, exp_g});
        last_gnt_dut = gnt;
        if (exp_v) begin
            check("rvalid", {31'b0, rvalid}, 32'd1);
            check("rdata", rdata, sb[0].data);
            check("err", {31'b0, err}, {31'b0, sb[0].err});
            void'(sb.pop_front());
        end else begin
            check("rvalid_idle", {31'b0, rvalid}, 32'd0);
            check("rdata_idle", rdata, 32'd0);
            check("err_idle", {31'b0, err}, 32'd0);
        end
        check("busy", {31'b0, busy}, {31'b0, (!rs && mcount != 0)});
        if (rs) begin
            sb.delete();
            mcount = 0;
        end else begin
            if (exp_g) begin
                sb.push_back('{due: cyc + LAT, idx: a[AW+1:2], err: (a[31:AW+2] != '0), data: '0});
            end
            mcount = mcount + (exp_g ? 1 : 0) - (exp_v ? 1 : 0);
            foreach (sb[i]) begin
                if (sb[i].due == cyc + 1) begin
                    sb[i].data = sb[i].err ? 32'd0 : mem_m[sb[i].idx];
                end
            end
        end
        if (we) mem_m[la] = wd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic preload(input logic [AW-1:0] la, input logic [31:0] wd);
        step(1'b0, '0, 1'b0, 1'b1, la, wd, 1'b0);
    endtask

    // Hold a request until the DUT grants it, bounded.
    task automatic hold_req(input logic [31:0] a);
        last_gnt_dut = 1'b0;
        for (int unsigned j = 0; j < 20 && !last_gnt_dut; j++) begin
            step(1'b1, a, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        check("hold_bound", {31'b0, last_gnt_dut}, 32'd1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 1'b1);

        for (int unsigned i = 0; i < 16; i++) preload(AW'(i), 32'hA500_0000 + i);
        preload(AW'(4), 32'hDEAD_BEEF);
        preload(AW'(7), 32'h0000_0011);

        step(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(3);

        hold_req(32'h0);
        hold_req(32'h4);
        hold_req(32'h8);
        idle(4);

        step(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(3);

        for (int i = 0; i < 3; i++) step(1'b1, 32'h20, 1'b1, 1'b0, '0, '0, 1'b0);
        hold_req(32'h20);
        idle(3);

        step(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(3);
        step(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(3);

        step(1'b1, 32'h1C, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, AW'(7), 32'h0000_0022, 1'b0);
        idle(2);
        step(1'b1, 32'h1C, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 9) == 0) a[31:AW+2] = 20'($urandom_range(1, 1000));
            step(1'b1 && ($urandom_range(0, 3) != 0), a, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 15)), $urandom(),
                 ($urandom_range(0, 60) == 0));
        end
        idle(6);
        check("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
